// File: rtl/i2s_rx_sync.sv
// Oversampling I2S / left-justified audio receiver running in the system clock domain.
// Assembles left/right pairs from the codec pins and hands them out over valid/ready.
module i2s_rx_sync #(
    parameter int DATA_BITS   = 16,
    parameter int SLOT_BITS   = 32,
    parameter int JUSTIFY     = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 codec_aud_bclk_i,
    input  logic                 codec_aud_adclrck_i,
    input  logic                 codec_aud_adcdat_i,
    input  logic                 enable_i,
    output logic [DATA_BITS-1:0] sample_L_o,
    output logic [DATA_BITS-1:0] sample_R_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 overrun_o,
    output logic                 frame_err_o
);
    localparam int IW = $clog2(SLOT_BITS + 2) + 2;
    localparam int SW = $clog2(SLOT_BITS + 2);

    localparam logic signed [IW-1:0] IDX_START = (JUSTIFY != 0) ? '0 : '1;
    localparam logic signed [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic signed [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic signed [IW-1:0] IDX_MAX   = IW'(SLOT_BITS + 1);
    localparam logic [SW-1:0]        SLOT_MAX  = SW'(SLOT_BITS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_RECV = 2'd2;

    logic [SYNC_STAGES-1:0] bclk_sync, lr_sync, dat_sync;
    logic                   bclk_last;
    logic                   rise_p0, lr_p0, dat_p0;
    logic                   lr_prev;

    logic [1:0]             state, state_nx;
    logic                   ch, ch_nx;
    logic signed [IW-1:0]   bit_idx, idx_nx;
    logic [SW-1:0]          slot_len, slot_len_nx;
    logic [DATA_BITS-1:0]   shreg, shreg_nx, left_hold;

    logic lr_edge, capture, short_slot, slot_over;
    logic frame_err_nx, left_done, pair_done;

    // Synchroniser and edge-detect stage (p0)
    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            dat_sync  <= '0;
            bclk_last <= 1'b0;
            rise_p0   <= 1'b0;
            lr_p0     <= 1'b0;
            dat_p0    <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], codec_aud_bclk_i};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], codec_aud_adclrck_i};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], codec_aud_adcdat_i};
            bclk_last <= bclk_sync[SYNC_STAGES-1];
            rise_p0   <= bclk_sync[SYNC_STAGES-1] & ~bclk_last;
            lr_p0     <= lr_sync[SYNC_STAGES-1];
            dat_p0    <= dat_sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        lr_edge = rise_p0 && (lr_p0 != lr_prev);

        if (lr_edge)
            idx_nx = IDX_START;
        else if (rise_p0 && (bit_idx < IDX_MAX))
            idx_nx = bit_idx + IDX_ONE;
        else
            idx_nx = bit_idx;

        capture  = rise_p0 && !idx_nx[IW-1] && (idx_nx <= IDX_LAST);
        shreg_nx = capture ? DATA_BITS'({shreg, dat_p0}) : shreg;

        if (lr_edge)
            slot_len_nx = SW'(1);
        else if (rise_p0 && (slot_len <= SLOT_MAX))
            slot_len_nx = slot_len + SW'(1);
        else
            slot_len_nx = slot_len;

        short_slot = lr_edge && (bit_idx < IDX_LAST);
        slot_over  = rise_p0 && !lr_edge && (slot_len >= SLOT_MAX);
    end

    // A short right slot ending on a left edge restarts capture on that same edge.
    always_comb begin
        state_nx     = state;
        ch_nx        = ch;
        frame_err_nx = 1'b0;
        if (!enable_i) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_nx = ST_SYNC;
                ST_SYNC: begin
                    if (lr_edge && !lr_p0) begin
                        state_nx = ST_RECV;
                        ch_nx    = 1'b0;
                    end
                end
                ST_RECV: begin
                    if (short_slot || slot_over) begin
                        frame_err_nx = 1'b1;
                        state_nx     = (short_slot && !lr_p0) ? ST_RECV : ST_SYNC;
                        ch_nx        = 1'b0;
                    end else if (lr_edge) begin
                        ch_nx = lr_p0;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
        left_done = capture && (state_nx == ST_RECV) && !ch_nx && (idx_nx == IDX_LAST);
        pair_done = capture && (state_nx == ST_RECV) &&  ch_nx && (idx_nx == IDX_LAST);
    end

    // Framing state and output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            lr_prev     <= 1'b0;
            state       <= ST_IDLE;
            ch          <= 1'b0;
            bit_idx     <= '0;
            slot_len    <= '0;
            shreg       <= '0;
            left_hold   <= '0;
            sample_L_o  <= '0;
            sample_R_o  <= '0;
            valid_o     <= 1'b0;
            overrun_o   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            if (rise_p0)
                lr_prev <= lr_p0;
            state       <= state_nx;
            ch          <= ch_nx;
            bit_idx     <= idx_nx;
            slot_len    <= slot_len_nx;
            shreg       <= shreg_nx;
            frame_err_o <= frame_err_nx;
            if (left_done)
                left_hold <= shreg_nx;

            if (pair_done && (!valid_o || ready_i)) begin
                sample_L_o <= left_hold;
                sample_R_o <= shreg_nx;
                valid_o    <= 1'b1;
            end else begin
                if (pair_done)
                    overrun_o <= 1'b1;
                if (valid_o && ready_i)
                    valid_o <= 1'b0;
            end

            if (!enable_i)
                overrun_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_rx_sync.sv
// Directed bench for i2s_rx_sync: an I2S instance and a left-justified instance share the pins.
module tb_i2s_rx_sync;
    logic clk, rst, bclk, lrck, adcdat, enable, ready;
    logic [15:0] l0, r0, l1, r1;
    logic v0, v1, ov0, ov1, fe0, fe1;

    i2s_rx_sync #(.DATA_BITS(16), .SLOT_BITS(32), .JUSTIFY(0), .SYNC_STAGES(2)) dut_i2s (
        .clk(clk), .rst(rst), .codec_aud_bclk_i(bclk), .codec_aud_adclrck_i(lrck),
        .codec_aud_adcdat_i(adcdat), .enable_i(enable), .sample_L_o(l0), .sample_R_o(r0),
        .valid_o(v0), .ready_i(ready), .overrun_o(ov0), .frame_err_o(fe0)
    );

    i2s_rx_sync #(.DATA_BITS(16), .SLOT_BITS(32), .JUSTIFY(1), .SYNC_STAGES(2)) dut_lj (
        .clk(clk), .rst(rst), .codec_aud_bclk_i(bclk), .codec_aud_adclrck_i(lrck),
        .codec_aud_adcdat_i(adcdat), .enable_i(enable), .sample_L_o(l1), .sample_R_o(r1),
        .valid_o(v1), .ready_i(ready), .overrun_o(ov1), .frame_err_o(fe1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: counts accepted pairs, error pulses and records valid rising edges.
    int acc0 = 0, acc1 = 0, err0 = 0, err1 = 0, vld_cyc0 = 0, vld_cyc1 = 0;
    logic [15:0] last_l0 = '0, last_r0 = '0, last_l1 = '0, last_r1 = '0;
    logic v0_prev = 1'b0, v1_prev = 1'b0;
    always @(negedge clk) begin
        v0_prev <= v0;
        v1_prev <= v1;
        if (v0 && !v0_prev) vld_cyc0 <= cyc;
        if (v1 && !v1_prev) vld_cyc1 <= cyc;
        if (v0 && ready) begin acc0 <= acc0 + 1; last_l0 <= l0; last_r0 <= r0; end
        if (v1 && ready) begin acc1 <= acc1 + 1; last_l1 <= l1; last_r1 <= r1; end
        if (fe0) err0 <= err0 + 1;
        if (fe1) err1 <= err1 + 1;
    end

    int tests = 0, fails = 0;
    int rise_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One slot: BCLK low phase carries the new LRCK/DATA, the rise samples it.
    task automatic send_slot(input logic lr, input logic [15:0] val, input logic just,
                             input int from_k, input int to_k);
        int idx;
        logic b;
        for (int k = from_k; k < to_k; k++) begin
            idx = just ? k : k - 1;
            b = (idx >= 0 && idx < 16) ? val[15-idx] : 1'b0;
            bclk = 1'b0; lrck = lr; adcdat = b;
            tick(4);
            bclk = 1'b1;
            if (lr && idx == 15) rise_cyc = cyc;
            tick(4);
        end
    endtask

    task automatic send_frame(input logic just, input logic [15:0] left, input logic [15:0] right,
                              input int llen, input int rlen);
        send_slot(1'b0, left, just, 0, llen);
        send_slot(1'b1, right, just, 0, rlen);
    endtask

    typedef struct {
        logic        just;
        logic [15:0] left;
        logic [15:0] right;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    vec_t vecs[6];
    int a0, a1, e0, e1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b0, 16'h1234, 16'hABCD, 16'h1234, 16'hABCD};
        vecs[1] = '{1'b1, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};
        vecs[2] = '{1'b1, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};
        vecs[3] = '{1'b1, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};
        vecs[4] = '{1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
        vecs[5] = '{1'b1, 16'h0001, 16'h8000, 16'h0001, 16'h8000};

        rst = 1'b1; enable = 1'b1; ready = 1'b1;
        bclk = 1'b0; lrck = 1'b1; adcdat = 1'b0;
        tick(3);
        check("rst_L", {16'h0, l0}, 32'h0);
        check("rst_R", {16'h0, r0}, 32'h0);
        check("rst_valid", {31'h0, v0}, 32'h0);
        check("rst_overrun", {31'h0, ov0}, 32'h0);
        check("rst_frame_err", {31'h0, fe0}, 32'h0);
        check("rst_lj_outputs", {l1, r1}, 32'h0);
        check("rst_lj_flags", {29'h0, v1, ov1, fe1}, 32'h0);
        rst = 1'b0;
        tick(2);

        // Preamble in a right slot so the first frame starts on a falling LRCK edge
        send_slot(1'b1, 16'h0000, 1'b0, 0, 4);

        for (int i = 0; i < 6; i++) begin
            a0 = acc0; a1 = acc1; e0 = err0; e1 = err1;
            send_frame(vecs[i].just, vecs[i].left, vecs[i].right, 32, 32);
            if (vecs[i].just) begin
                check("vec_count_lj", acc1 - a1, 1);
                check("vec_L_lj", {16'h0, last_l1}, {16'h0, vecs[i].exp_l});
                check("vec_R_lj", {16'h0, last_r1}, {16'h0, vecs[i].exp_r});
                check("vec_latency_lj", vld_cyc1 - rise_cyc, 4);
                check("vec_no_err_lj", err1 - e1, 0);
            end else begin
                check("vec_count_i2s", acc0 - a0, 1);
                check("vec_L_i2s", {16'h0, last_l0}, {16'h0, vecs[i].exp_l});
                check("vec_R_i2s", {16'h0, last_r0}, {16'h0, vecs[i].exp_r});
                check("vec_latency_i2s", vld_cyc0 - rise_cyc, 4);
                check("vec_no_err_i2s", err0 - e0, 0);
            end
        end

        // Back-pressure: A is held, B is dropped, C follows after acceptance
        ready = 1'b0;
        send_frame(1'b0, 16'h1111, 16'h2222, 32, 32);
        check("bp_valid_A", {31'h0, v0}, 32'h1);
        check("bp_hold_L_A", {16'h0, l0}, 32'h1111);
        check("bp_hold_R_A", {16'h0, r0}, 32'h2222);
        check("bp_no_overrun_A", {31'h0, ov0}, 32'h0);
        send_frame(1'b0, 16'h3333, 16'h4444, 32, 32);
        check("bp_overrun_B", {31'h0, ov0}, 32'h1);
        check("bp_hold_L_B", {16'h0, l0}, 32'h1111);
        check("bp_hold_R_B", {16'h0, r0}, 32'h2222);
        check("bp_valid_B", {31'h0, v0}, 32'h1);
        a0 = acc0;
        ready = 1'b1;
        tick(1);
        check("bp_valid_drop", {31'h0, v0}, 32'h0);
        check("bp_accept_count", acc0 - a0, 1);
        check("bp_accept_L", {16'h0, last_l0}, 32'h1111);
        check("bp_accept_R", {16'h0, last_r0}, 32'h2222);
        a0 = acc0;
        send_frame(1'b0, 16'h5555, 16'h6666, 32, 32);
        check("bp_C_count", acc0 - a0, 1);
        check("bp_C_L", {16'h0, last_l0}, 32'h5555);
        check("bp_C_R", {16'h0, last_r0}, 32'h6666);
        check("bp_overrun_sticky", {31'h0, ov0}, 32'h1);
        enable = 1'b0;
        tick(2);
        check("disable_clears_overrun", {31'h0, ov0}, 32'h0);
        enable = 1'b1;
        tick(1);

        // Short left slot
        a0 = acc0; e0 = err0;
        send_frame(1'b0, 16'hAAAA, 16'h5555, 10, 32);
        check("short_err_pulse", err0 - e0, 1);
        check("short_no_valid", acc0 - a0, 0);
        send_frame(1'b0, 16'h0F0F, 16'hF0F0, 32, 32);
        check("short_recover_count", acc0 - a0, 1);
        check("short_recover_L", {16'h0, last_l0}, 32'h0F0F);
        check("short_recover_R", {16'h0, last_r0}, 32'hF0F0);
        check("short_single_err", err0 - e0, 1);

        // Reset pulse mid right slot
        a0 = acc0;
        send_slot(1'b0, 16'hDDDD, 1'b0, 0, 32);
        send_slot(1'b1, 16'hEEEE, 1'b0, 0, 8);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_L", {16'h0, l0}, 32'h0);
        check("midrst_R", {16'h0, r0}, 32'h0);
        check("midrst_flags", {29'h0, v0, ov0, fe0}, 32'h0);
        send_slot(1'b1, 16'hEEEE, 1'b0, 8, 32);
        send_frame(1'b0, 16'h1357, 16'h2468, 32, 32);
        check("midrst_count", acc0 - a0, 1);
        check("midrst_L_next", {16'h0, last_l0}, 32'h1357);
        check("midrst_R_next", {16'h0, last_r0}, 32'h2468);

        // Enable raised mid right slot
        enable = 1'b0;
        tick(1);
        a0 = acc0; e0 = err0;
        send_slot(1'b0, 16'h9999, 1'b0, 0, 32);
        send_slot(1'b1, 16'h7777, 1'b0, 0, 5);
        enable = 1'b1;
        send_slot(1'b1, 16'h7777, 1'b0, 5, 32);
        check("enable_partial_ignored", acc0 - a0, 0);
        send_frame(1'b0, 16'h4321, 16'h8765, 32, 32);
        check("enable_count", acc0 - a0, 1);
        check("enable_L", {16'h0, last_l0}, 32'h4321);
        check("enable_R", {16'h0, last_r0}, 32'h8765);
        check("enable_no_err", err0 - e0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2s_rx_sync.md
Name: i2s_rx_sync

Overview:
Parametrised I2S / left-justified audio receiver for the codec ADC path. It runs entirely in the system clock domain and oversamples the codec BCLK, LRCK and DATA pins. It assembles left/right sample pairs, checks slot framing, and delivers each pair through a valid/ready handshake. It sits between the codec pins and the sample buffer feeding the spectrum FFT, and detects overrun and framing errors.

Parameters:
DATA_BITS, 16, sample width per channel (1..32)
SLOT_BITS, 32, maximum BCLK rises per LRCK half-period (>= DATA_BITS+1)
JUSTIFY, 0, 0 = I2S (one delay bit after LRCK edge), 1 = left-justified (MSB on LRCK edge)
SYNC_STAGES, 2, synchroniser flops on each codec pin (>= 2)

Ports:
clk  input  1  system clock, must be >= 4x BCLK frequency
rst  input  1  synchronous reset, active-high
codec_aud_bclk_i  input  1  codec bit clock (asynchronous)
codec_aud_adclrck_i  input  1  codec LRCK, low = left, high = right (asynchronous)
codec_aud_adcdat_i  input  1  codec serial data, MSB first (asynchronous)
enable_i  input  1  receiver enable
sample_L_o  output  DATA_BITS  left sample, raw two's complement
sample_R_o  output  DATA_BITS  right sample, raw two's complement
valid_o  output  1  sample pair available
ready_i  input  1  consumer accepts the pair when valid_o & ready_i
overrun_o  output  1  sticky: a completed pair was dropped
frame_err_o  output  1  one-clk pulse on a framing violation

Behaviour:
- Reset is synchronous and active-high; one clock domain (clk). On rst: sample_L_o=0, sample_R_o=0, valid_o=0, overrun_o=0, frame_err_o=0, FSM=IDLE, all counters and shift registers cleared.
- Each pin passes through SYNC_STAGES flops. bclk_rise = synced BCLK high & previous synced BCLK low. All sampling happens only on bclk_rise cycles; LRCK and DATA are read from their synced values on that cycle.
- lr_edge = LRCK sampled now != LRCK sampled at the previous bclk_rise.
- Bit index: on an lr_edge rise, bit_idx is set to 0 (JUSTIFY=1; this rise is data bit 0) or to -1 (JUSTIFY=0; this rise is the delay bit, not captured). bit_idx increments on every following rise. Bit bit_idx is captured MSB-first while 0 <= bit_idx < DATA_BITS. Later bits are ignored.
- slot_len counts rises since the last lr_edge, saturating at SLOT_BITS+1.
- FSM:
  - IDLE: entered when enable_i=0. Stays in IDLE while enable_i=0; moves to SYNC when enable_i=1.
  - SYNC: waits for an lr_edge to low (start of a left slot), then moves to RECV. Left is always received first.
  - RECV: captures the left slot, then the right slot.
    - If an lr_edge arrives with fewer than DATA_BITS bits captured in the current slot, or slot_len exceeds SLOT_BITS, then: frame_err_o pulses for 1 clk, the partial pair is discarded, FSM goes to SYNC.
    - A short slot that ends exactly at the start of a left slot resyncs on that same edge.
- Pair completion happens on the rise that captures right bit DATA_BITS-1:
  - If valid_o=0, or ready_i=1 in that same cycle: sample_L_o/sample_R_o are loaded and valid_o=1 on the next clk.
  - If valid_o=1 and ready_i=0: the new pair is dropped, the held outputs are unchanged, and overrun_o is set.
- Latency: valid_o rises SYNC_STAGES+2 clk after the BCLK pin rising edge carrying the last right bit.
- Handshake:
  - valid_o stays high until valid_o & ready_i.
  - Outputs are stable while valid_o=1.
  - valid_o clears the cycle after acceptance unless a new pair loads in that same cycle.
- enable_i=0 mid-frame: the partial frame is discarded and overrun_o is cleared. A pending valid pair remains deliverable.
- overrun_o clears only on rst or enable_i=0.
- frame_err_o and completion cannot coincide, because completion needs DATA_BITS captured bits.

Test Plan:
1. JUSTIFY=0, DATA_BITS=16, SLOT_BITS=32, clk=8x BCLK, ready_i=1; send L=0x1234, R=0xABCD -> one valid_o pulse with sample_L_o=0x1234 and sample_R_o=0xABCD, arriving SYNC_STAGES+2 clk after the last R bit edge.
2. JUSTIFY=1; send L=0x8001, R=0x7FFE for three frames -> three valid_o pulses with exact values and no frame_err_o.
3. ready_i=0; send frames A(0x1111/0x2222) then B(0x3333/0x4444) -> outputs hold A, overrun_o=1 after B completes; raise ready_i -> valid_o drops, and the next frame C is delivered.
4. Left slot of only 10 BCLK -> frame_err_o single pulse, no valid_o; next full frame 0x0F0F/0xF0F0 is delivered correctly.
5. Assert rst for 1 clk mid right slot -> all outputs 0 next clk; the following full frame is captured correctly after resync.
6. Raise enable_i mid right slot -> that partial right slot is ignored; the first delivered pair is the next complete left+right frame.
